// File: rtl/ftdnn_pkg.sv
// Shared definitions for the FTDNN array controller: FSM states and row-address width.
`ifndef HW_D3
`define HW_D3 4
`endif
`ifndef ACTBUF_DATA_LEN
`define ACTBUF_DATA_LEN 8
`endif
`ifndef HW_XLT_LEN
`define HW_XLT_LEN 16
`endif
`ifndef PBUF_DATA_LEN
`define PBUF_DATA_LEN 8
`endif
`ifndef HW_D2
`define HW_D2 4
`endif

package ftdnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CFG   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } ftdnn_state_e;

    // Row index width; a single row still needs one address bit.
    function automatic int row_aw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ftdnn_rr_arb.sv
// Round-robin arbiter: one-hot grant, search begins one past the last granted row.
module ftdnn_rr_arb
    import ftdnn_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk_h,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = row_aw(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] idx;
    logic          found;

    // First requester at or after ptr, wrapping around.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

    // Pointer moves past the winner only when the grant is actually consumed.
    always_ff @(posedge clk_h) begin
        if (!rst_n)
            ptr <= '0;
        else if (advance && found)
            ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    end

endmodule

// File: rtl/ftdnn_array_ctrl.sv
// FTDNN sblk array controller: parameter load, activation broadcast, pbuf drain.
module ftdnn_array_ctrl
    import ftdnn_pkg::*;
#(
    parameter int N_ROWS      = `HW_D3,
    parameter int ACT_W       = 2*`ACTBUF_DATA_LEN,
    parameter int PARAM_W     = `HW_XLT_LEN,
    parameter int PBUF_W      = `PBUF_DATA_LEN*`HW_D2,
    parameter int DRAIN_WORDS = 8,
    localparam int ROW_AW     = row_aw(N_ROWS)
) (
    input  logic                     clk_h,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [N_ROWS-1:0]        cfg_row_en,
    input  logic [PARAM_W-1:0]       param_data,
    input  logic [ROW_AW-1:0]        param_row,
    input  logic                     param_bcast,
    input  logic                     param_last,
    input  logic                     param_vld,
    output logic                     param_rdy,
    output logic [PARAM_W-1:0]       row_param,
    output logic [N_ROWS-1:0]        row_param_en,
    input  logic [ACT_W-1:0]         act_data,
    input  logic                     act_vld,
    output logic                     act_rdy,
    input  logic [N_ROWS-1:0]        row_act_req,
    output logic [ACT_W-1:0]         row_act_data,
    output logic                     row_act_vld,
    input  logic [N_ROWS-1:0]        row_status,
    input  logic [N_ROWS*PBUF_W-1:0] row_pbuf_data,
    input  logic [N_ROWS-1:0]        row_pbuf_vld,
    output logic [N_ROWS-1:0]        row_pbuf_rdy,
    output logic [PBUF_W-1:0]        out_data,
    output logic [ROW_AW-1:0]        out_row,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);
    localparam int CNT_W = $clog2(N_ROWS*DRAIN_WORDS + 1);

    ftdnn_state_e        state, state_nxt;
    logic [N_ROWS-1:0]   en_q;
    logic [CNT_W-1:0]    word_cnt, ld_cnt, pop, total;
    logic                start_ok, param_acc, param_drop, out_hs, last_hs, space_ok, pbuf_hs;
    logic [N_ROWS-1:0]   row_onehot, param_mask, arb_req, arb_grant;
    logic                arb_rst_n;
    logic [PBUF_W-1:0]   sel_data;
    logic [ROW_AW-1:0]   sel_row;

    // Words expected this job: enabled rows times words per row.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_ROWS; i++)
            pop = pop + CNT_W'(en_q[i]);
        total = CNT_W'(int'(pop) * DRAIN_WORDS);
    end

    // Parameter routing: broadcast goes to all enabled rows; an address
    // outside the array or outside the mask yields an empty mask (dropped).
    always_comb begin
        row_onehot = (N_ROWS)'(1) << param_row;
        param_mask = param_bcast ? en_q : (row_onehot & en_q);
        param_drop = ~param_bcast & ~|param_mask;
    end

    assign start_ok  = (state == IDLE) && start && |cfg_row_en && !abort;
    assign param_acc = param_vld && param_rdy;
    assign out_hs    = out_vld && out_rdy;
    assign last_hs   = (state == DRAIN) && out_hs && (word_cnt == total - CNT_W'(1));
    assign space_ok  = !out_vld || out_rdy;
    assign busy      = (state != IDLE);

    // Only enabled, valid rows compete, and only while words are still owed.
    assign arb_req   = ((state == DRAIN) && (ld_cnt < total)) ? (en_q & row_pbuf_vld) : '0;
    // Holding the arbiter in reset outside DRAIN restarts the search at row 0.
    assign arb_rst_n = rst_n && (state == DRAIN);
    assign row_pbuf_rdy = space_ok ? arb_grant : '0;
    assign pbuf_hs   = |row_pbuf_rdy;

    ftdnn_rr_arb #(.N(N_ROWS)) u_arb (
        .clk_h   (clk_h),
        .rst_n   (arb_rst_n),
        .req     (arb_req),
        .advance (pbuf_hs),
        .grant   (arb_grant)
    );

    // Select the granted row's word and index.
    always_comb begin
        sel_data = '0;
        sel_row  = '0;
        for (int i = 0; i < N_ROWS; i++) begin
            if (arb_grant[i]) begin
                sel_data = row_pbuf_data[i*PBUF_W +: PBUF_W];
                sel_row  = ROW_AW'(i);
            end
        end
    end

    // Next-state and handshake outputs; abort overrides everything.
    always_comb begin
        state_nxt = state;
        param_rdy = (state == CFG);
        act_rdy   = (state == RUN) && &(row_act_req | ~en_q);
        done      = last_hs && !abort;
        case (state)
            IDLE:    if (start_ok) state_nxt = CFG;
            CFG:     if (param_vld && param_last) state_nxt = RUN;
            RUN:     if (&(row_status | ~en_q)) state_nxt = DRAIN;
            DRAIN:   if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // State register.
    always_ff @(posedge clk_h) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Job context: row mask, sticky address error, load/output word counters.
    always_ff @(posedge clk_h) begin
        if (!rst_n) begin
            en_q     <= '0;
            cfg_err  <= 1'b0;
            word_cnt <= '0;
            ld_cnt   <= '0;
        end else if (abort) begin
            word_cnt <= '0;
            ld_cnt   <= '0;
        end else if (start_ok) begin
            en_q     <= cfg_row_en;
            cfg_err  <= 1'b0;
            word_cnt <= '0;
            ld_cnt   <= '0;
        end else begin
            if (param_acc && param_drop) cfg_err <= 1'b1;
            if (pbuf_hs) ld_cnt <= ld_cnt + CNT_W'(1);
            if ((state == DRAIN) && out_hs) word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    // Parameter strobe register; dropped words leave row_param untouched.
    always_ff @(posedge clk_h) begin
        if (!rst_n || abort) begin
            row_param    <= '0;
            row_param_en <= '0;
        end else begin
            row_param_en <= param_acc ? param_mask : '0;
            if (param_acc && |param_mask) row_param <= param_data;
        end
    end

    // Activation broadcast register, one cycle behind the handshake.
    always_ff @(posedge clk_h) begin
        if (!rst_n || abort) begin
            row_act_data <= '0;
            row_act_vld  <= 1'b0;
        end else begin
            row_act_vld <= act_vld && act_rdy;
            if (act_vld && act_rdy) row_act_data <= act_data;
        end
    end

    // Output register: reload on every pbuf handshake, otherwise hold until taken.
    always_ff @(posedge clk_h) begin
        if (!rst_n || abort) begin
            out_data <= '0;
            out_row  <= '0;
            out_vld  <= 1'b0;
        end else if (pbuf_hs) begin
            out_data <= sel_data;
            out_row  <= sel_row;
            out_vld  <= 1'b1;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ftdnn_array_ctrl.sv
// Self-checking bench for ftdnn_array_ctrl with a queue-based drain model.
module tb_ftdnn_array_ctrl;
    localparam int N = 4, AW = 16, PW = 16, BW = 32, DW = 2, RAW = 2;

    logic            clk_h = 0, rst_n = 0, start = 0, abort = 0;
    logic [N-1:0]    cfg_row_en = 0;
    logic [PW-1:0]   param_data = 0;
    logic [RAW-1:0]  param_row = 0;
    logic            param_bcast = 0, param_last = 0, param_vld = 0, param_rdy;
    logic [PW-1:0]   row_param;
    logic [N-1:0]    row_param_en;
    logic [AW-1:0]   act_data = 0;
    logic            act_vld = 0, act_rdy;
    logic [N-1:0]    row_act_req = 0;
    logic [AW-1:0]   row_act_data;
    logic            row_act_vld;
    logic [N-1:0]    row_status = 0;
    logic [N*BW-1:0] row_pbuf_data;
    logic [N-1:0]    row_pbuf_vld, row_pbuf_rdy;
    logic [BW-1:0]   out_data;
    logic [RAW-1:0]  out_row;
    logic            out_vld, out_rdy = 0, busy, done, cfg_err;
    logic [80:0]     all_out;

    logic [BW-1:0]   src [N][DW];
    int              idx [N];
    logic            src_on = 0, src_clr = 0;
    int              n_cmp = 0, n_err = 0;

    ftdnn_array_ctrl #(.N_ROWS(N), .ACT_W(AW), .PARAM_W(PW), .PBUF_W(BW), .DRAIN_WORDS(DW)) dut (
        .clk_h(clk_h), .rst_n(rst_n), .start(start), .abort(abort), .cfg_row_en(cfg_row_en),
        .param_data(param_data), .param_row(param_row), .param_bcast(param_bcast),
        .param_last(param_last), .param_vld(param_vld), .param_rdy(param_rdy),
        .row_param(row_param), .row_param_en(row_param_en), .act_data(act_data),
        .act_vld(act_vld), .act_rdy(act_rdy), .row_act_req(row_act_req),
        .row_act_data(row_act_data), .row_act_vld(row_act_vld), .row_status(row_status),
        .row_pbuf_data(row_pbuf_data), .row_pbuf_vld(row_pbuf_vld), .row_pbuf_rdy(row_pbuf_rdy),
        .out_data(out_data), .out_row(out_row), .out_vld(out_vld), .out_rdy(out_rdy),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    assign all_out = {param_rdy, act_rdy, row_param_en, row_act_vld, row_pbuf_rdy, out_vld,
                      busy, done, cfg_err, row_param, row_act_data, out_data, out_row};

    always #5 clk_h = ~clk_h;

    // Row pbuf sources: each row offers DW words; disabled rows keep offering forever.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            row_pbuf_vld[i]            = src_on && (idx[i] < DW);
            row_pbuf_data[i*BW +: BW]  = src[i][(idx[i] < DW) ? idx[i] : 0];
        end
    end

    always @(posedge clk_h) begin
        for (int i = 0; i < N; i++) begin
            if (src_clr) idx[i] <= 0;
            else if (row_pbuf_vld[i] && row_pbuf_rdy[i]) idx[i] <= idx[i] + 1;
        end
    end

    task automatic step();
        @(posedge clk_h); #1;
    endtask

    task automatic prep_src();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < DW; k++) src[i][k] = $urandom;
        src_on = 1; src_clr = 1; step(); src_clr = 0;
    endtask

    task automatic start_job(input logic [N-1:0] m);
        prep_src();
        row_status = 0; row_act_req = 0;
        cfg_row_en = m; start = 1; step(); start = 0; cfg_row_en = N'($urandom);
        @(negedge clk_h);
        n_cmp++;
        if (busy !== 1'b1 || param_rdy !== 1'b1 || cfg_err !== 1'b0) begin
            n_err++; $display("FAIL start_job: busy=%0b param_rdy=%0b cfg_err=%0b want 1 1 0", busy, param_rdy, cfg_err);
        end
    endtask

    task automatic send_last();
        param_vld = 1; param_bcast = 1; param_last = 1; param_data = PW'($urandom);
        step();
        param_vld = 0; param_last = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; step(); step();
        @(negedge clk_h);
        n_cmp++;
        if (all_out !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        rst_n = 1;
    endtask

    task automatic test_start_ignore();
        cfg_row_en = 0; start = 1; step(); start = 0;
        @(negedge clk_h);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL zero_mask_start: busy=%0b want 0", busy); end
        cfg_row_en = 4'b1011; start = 1; abort = 1; step(); start = 0; abort = 0;
        @(negedge clk_h);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL abort_over_start: busy=%0b want 0", busy); end
    endtask

    // Back-to-back parameter words: broadcast, addressed, dropped, last.
    task automatic test_cfg(input logic [N-1:0] m);
        bit            bc_t [7] = '{1, 1, 1, 0, 0, 0, 1};
        int            row_t[7] = '{0, 0, 0, 1, 2, 3, 0};
        logic [PW-1:0] fwd = 0, wd;
        logic [N-1:0]  exp_en;
        bit            err = 0;
        start_job(m);
        row_act_req = '1;
        for (int k = 0; k < 7; k++) begin
            param_vld = 1; param_bcast = bc_t[k]; param_last = (k == 6);
            param_row = bc_t[k] ? RAW'($urandom) : RAW'(row_t[k]);
            param_data = PW'($urandom); wd = param_data;
            exp_en = bc_t[k] ? m : ((4'b0001 << row_t[k]) & m);
            if (exp_en != 0) fwd = wd; else err = 1;
            step();
            @(negedge clk_h);
            n_cmp++;
            if (row_param_en !== exp_en || row_param !== fwd || cfg_err !== err) begin
                n_err++; $display("FAIL param_word%0d: en=%b data=%h err=%0b want en=%b data=%h err=%0b",
                                  k, row_param_en, row_param, cfg_err, exp_en, fwd, err);
            end
            n_cmp++;
            if (act_rdy !== (k == 6) || row_pbuf_rdy !== 0) begin
                n_err++; $display("FAIL cfg_side: act_rdy=%0b pbuf_rdy=%b want %0b 0", act_rdy, row_pbuf_rdy, (k == 6));
            end
        end
        param_vld = 0; param_last = 0;
        n_cmp++;
        if (param_rdy !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL cfg_to_run: param_rdy=%0b busy=%0b want 0 1", param_rdy, busy);
        end
    endtask

    task automatic test_act(input logic [N-1:0] m);
        bit            prev_vld, exp_rdy;
        logic [AW-1:0] prev_dat;
        row_act_req = 4'b0011; #1;
        n_cmp++;
        if (act_rdy !== 1'b0) begin n_err++; $display("FAIL act_rdy_missing: got %0b want 0", act_rdy); end
        row_act_req = 4'b1011; #1;
        n_cmp++;
        if (act_rdy !== 1'b1) begin n_err++; $display("FAIL act_rdy_set: got %0b want 1", act_rdy); end
        act_data = 16'h00A5; act_vld = 1; step(); act_vld = 0;
        @(negedge clk_h);
        n_cmp++;
        if (row_act_vld !== 1'b1 || row_act_data !== 16'h00A5) begin
            n_err++; $display("FAIL act_a5: vld=%0b data=%h want 1 00a5", row_act_vld, row_act_data);
        end
        prev_vld = 1; prev_dat = 16'h00A5;
        for (int k = 0; k < 24; k++) begin
            row_act_req = N'($urandom); act_vld = 1'($urandom); act_data = AW'($urandom); #1;
            exp_rdy = ((row_act_req | ~m) == 4'hF);
            n_cmp++;
            if (act_rdy !== exp_rdy) begin n_err++; $display("FAIL act_rdy_rand: req=%b got %0b want %0b", row_act_req, act_rdy, exp_rdy); end
            n_cmp++;
            if (row_act_vld !== prev_vld || (prev_vld && row_act_data !== prev_dat)) begin
                n_err++; $display("FAIL act_fwd: vld=%0b data=%h want %0b %h", row_act_vld, row_act_data, prev_vld, prev_dat);
            end
            prev_vld = act_vld && exp_rdy; prev_dat = act_data;
            @(negedge clk_h);
        end
        act_vld = 0; #1;
        n_cmp++;
        if (row_act_vld !== prev_vld || (prev_vld && row_act_data !== prev_dat)) begin
            n_err++; $display("FAIL act_fwd_last: vld=%0b want %0b", row_act_vld, prev_vld);
        end
    endtask

    // Drain checker: expected stream from a round-robin walk over per-row word counts.
    task automatic run_drain(input logic [N-1:0] m, input bit stall);
        int            exp_row[$];
        logic [BW-1:0] exp_dat[$];
        int            rem[N];
        int            ptr = 0, total = 0, hs = 0, cyc = 0, r;
        bit            held = 0, seen = 0;
        logic [BW-1:0] hd = 0;
        logic [RAW-1:0] hr = 0;
        for (int i = 0; i < N; i++) begin rem[i] = m[i] ? DW : 0; total += rem[i]; end
        while (exp_row.size() < total) begin
            for (int j = 0; j < N; j++) begin
                r = (ptr + j) % N;
                if (rem[r] > 0) begin
                    exp_row.push_back(r); exp_dat.push_back(src[r][DW - rem[r]]);
                    rem[r]--; ptr = (r + 1) % N;
                    break;
                end
            end
        end
        while (hs < total && cyc < 200) begin
            out_rdy = stall ? ((cyc >= 3 && cyc < 8) ? 1'b0 : 1'($urandom)) : 1'b1;
            #1;
            n_cmp++;
            if ((row_pbuf_rdy & ~m) != 0) begin n_err++; $display("FAIL foreign_ack: rdy=%b mask=%b", row_pbuf_rdy, m); end
            if (held) begin
                n_cmp++;
                if (out_vld !== 1'b1 || out_data !== hd || out_row !== hr) begin
                    n_err++; $display("FAIL out_hold: vld=%0b data=%h row=%0d want 1 %h %0d", out_vld, out_data, out_row, hd, hr);
                end
            end
            if (out_vld && !out_rdy) begin
                n_cmp++;
                if (row_pbuf_rdy !== 0) begin n_err++; $display("FAIL stall_rdy: rdy=%b want 0", row_pbuf_rdy); end
                held = 1; hd = out_data; hr = out_row;
            end else held = 0;
            if (!stall && seen) begin
                n_cmp++;
                if (out_vld !== 1'b1) begin n_err++; $display("FAIL throughput: out_vld=0 at cycle %0d want 1", cyc); end
            end
            if (out_vld && out_rdy) begin
                hs++; seen = 1;
                n_cmp++;
                if (out_row !== RAW'(exp_row[0]) || out_data !== exp_dat[0]) begin
                    n_err++; $display("FAIL drain_word%0d: row=%0d data=%h want %0d %h", hs, out_row, out_data, exp_row[0], exp_dat[0]);
                end
                void'(exp_row.pop_front()); void'(exp_dat.pop_front());
                n_cmp++;
                if (done !== (hs == total)) begin n_err++; $display("FAIL done_pulse: hs=%0d done=%0b want %0b", hs, done, (hs == total)); end
            end else begin
                n_cmp++;
                if (done !== 1'b0) begin n_err++; $display("FAIL done_early: done=1 want 0 at cycle %0d", cyc); end
            end
            cyc++;
            @(negedge clk_h);
        end
        n_cmp++;
        if (hs != total) begin n_err++; $display("FAIL drain_timeout: words=%0d want %0d", hs, total); end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || out_vld !== 1'b0 || row_pbuf_rdy !== 0) begin
            n_err++; $display("FAIL drain_end: busy=%0b done=%0b out_vld=%0b rdy=%b want 0", busy, done, out_vld, row_pbuf_rdy);
        end
    endtask

    task automatic test_drain_full(input logic [N-1:0] m);
        logic [AW-1:0] ad;
        row_act_req = '1; act_vld = 1; act_data = AW'($urandom); ad = act_data;
        row_status = m; out_rdy = 1;
        step(); act_vld = 0;
        @(negedge clk_h);
        n_cmp++;
        if (row_act_vld !== 1'b1 || row_act_data !== ad) begin
            n_err++; $display("FAIL act_on_run_exit: vld=%0b data=%h want 1 %h", row_act_vld, row_act_data, ad);
        end
        run_drain(m, 0);
    endtask

    task automatic test_drain_stall();
        logic [N-1:0] m;
        for (int it = 0; it < 3; it++) begin
            m = N'($urandom_range(1, 15));
            start_job(m);
            row_status = '1;
            send_last();
            @(negedge clk_h);
            n_cmp++;
            if (row_pbuf_rdy !== 0 || busy !== 1'b1) begin
                n_err++; $display("FAIL run_no_ack: rdy=%b busy=%0b want 0 1", row_pbuf_rdy, busy);
            end
            @(negedge clk_h);
            run_drain(m, (it != 1));
        end
    endtask

    task automatic test_abort_run();
        start_job(N'($urandom_range(1, 15)));
        send_last();
        row_act_req = '1; act_vld = 1; act_data = AW'($urandom); abort = 1;
        step(); abort = 0; act_vld = 0;
        @(negedge clk_h);
        n_cmp++;
        if (all_out !== '0) begin n_err++; $display("FAIL abort_outputs: got %h want 0", all_out); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_h);
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL abort_idle: busy=%0b done=%0b want 0 0", busy, done); end
        end
    endtask

    task automatic test_reset_drain();
        start_job(4'b1011);
        row_status = '1;
        send_last();
        out_rdy = 0;
        step(); step(); step();
        @(negedge clk_h);
        n_cmp++;
        if (out_vld !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL drain_loaded: out_vld=%0b done=%0b want 1 0", out_vld, done); end
        rst_n = 0; step();
        @(negedge clk_h);
        n_cmp++;
        if (all_out !== '0) begin n_err++; $display("FAIL reset_mid_drain: got %h want 0", all_out); end
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_h);
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL post_reset: busy=%0b done=%0b want 0 0", busy, done); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start_ignore();
        test_cfg(4'b1011);
        test_act(4'b1011);
        test_drain_full(4'b1011);
        test_drain_stall();
        test_abort_run();
        test_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ftdnn_array_ctrl.md
FTDNN_ARRAY_CTRL -- requirements
Module: ftdnn_array_ctrl

Interface
REQ-001 SHALL have parameter N_ROWS, default `HW_D3: number of sblk rows controlled (1..16).
REQ-002 SHALL have parameter ACT_W, default 2*`ACTBUF_DATA_LEN: activation word width.
REQ-003 SHALL have parameter PARAM_W, default `HW_XLT_LEN: parameter word width.
REQ-004 SHALL have parameter PBUF_W, default `PBUF_DATA_LEN*`HW_D2: per-row pbuf word width.
REQ-005 SHALL have parameter DRAIN_WORDS, default 8: pbuf words each enabled row delivers per job.
REQ-006 SHALL use one clock, clk_h; reset rst_n is synchronous, active-low.
REQ-007 Ports SHALL be:
- clk_h  in  1  clock
- rst_n  in  1  sync active-low reset
- start  in  1  job start pulse
- abort  in  1  sync job abort
- cfg_row_en  in  N_ROWS  row participation mask
- param_data  in  PARAM_W  parameter word
- param_row  in  ROW_AW  target row (ROW_AW = clog2(N_ROWS), min 1)
- param_bcast  in  1  write to all enabled rows
- param_last  in  1  final parameter word
- param_vld / param_rdy  in / out  1  parameter handshake
- row_param  out  PARAM_W  parameter to rows
- row_param_en  out  N_ROWS  per-row parameter strobe
- act_data  in  ACT_W  activation word
- act_vld / act_rdy  in / out  1  activation handshake
- row_act_req  in  N_ROWS  row can accept activation
- row_act_data  out  ACT_W  broadcast activation
- row_act_vld  out  1  activation strobe
- row_status  in  N_ROWS  row compute done (level)
- row_pbuf_data  in  N_ROWS*PBUF_W  packed pbuf words, row i at [i*PBUF_W +: PBUF_W]
- row_pbuf_vld / row_pbuf_rdy  in / out  N_ROWS  per-row pbuf handshake
- out_data  out  PBUF_W  merged pbuf stream
- out_row  out  ROW_AW  source row of out_data
- out_vld / out_rdy  out / in  1  output handshake
- busy  out  1  state != IDLE
- done  out  1  one-cycle job-complete pulse
- cfg_err  out  1  sticky bad-address flag

Function
REQ-008 FSM SHALL have states IDLE, CFG, RUN, DRAIN.
REQ-009 IDLE->CFG on start when cfg_row_en != 0; en_q latched from cfg_row_en; start with zero mask SHALL be ignored.
REQ-010 In CFG, param_rdy SHALL be 1; each accepted word SHALL drive row_param = param_data next cycle with row_param_en = en_q (bcast) or one-hot(param_row) (addressed).
REQ-011 Addressed word with param_row >= N_ROWS or row not in en_q SHALL be dropped (row_param_en = 0) and SHALL set cfg_err; cfg_err clears only on reset or start.
REQ-012 CFG->RUN on the accepted word carrying param_last.
REQ-013 In RUN, act_rdy SHALL equal &(row_act_req | ~en_q), combinationally; 0 in other states.
REQ-014 Accepted activation SHALL appear on row_act_data with row_act_vld = 1 exactly one cycle later; row_act_vld = 0 otherwise.
REQ-015 RUN->DRAIN when &(row_status | ~en_q) = 1; a handshake completing that same cycle SHALL still be forwarded.
REQ-016 In DRAIN, a round-robin arbiter over rows with en_q & row_pbuf_vld SHALL grant one row; search starts at the row after the last grant, initially row 0 on DRAIN entry.
REQ-017 row_pbuf_rdy SHALL be one-hot to the granted row, asserted only when the output register is empty or out_rdy = 1 this cycle; 0 outside DRAIN.
REQ-018 Output register SHALL load data/row index on a pbuf handshake; out_vld SHALL hold with out_data/out_row stable until out_rdy; full throughput (1 word/cycle) SHALL be sustained when out_rdy = 1.
REQ-019 Word counter SHALL count out_vld & out_rdy; at popcount(en_q)*DRAIN_WORDS, FSM SHALL go DRAIN->IDLE and done SHALL pulse that cycle.
REQ-020 abort SHALL force IDLE next cycle from any state, discarding the output register and suppressing done; abort has priority over start.
REQ-021 Row pbuf words arriving outside DRAIN or from rows not in en_q SHALL never be acknowledged.

Reset
REQ-022 On rst_n = 0 at clk_h edge: state IDLE, en_q = 0, counters 0, RR pointer 0; all outputs 0 (param_rdy, act_rdy, row_param_en, row_act_vld, row_pbuf_rdy, out_vld, busy, done, cfg_err; data outputs 0).
REQ-023 Reset mid-job SHALL behave as REQ-022 with no done pulse.

Structure
REQ-024 State enum and the ROW_AW computation SHALL reside in shared package ftdnn_pkg.
REQ-025 Round-robin arbiter SHALL be sub-module ftdnn_rr_arb (parameter N; inputs req, advance; output one-hot grant).

Verification
REQ-026 N_ROWS=4, mask 4'b1011, start, 3 bcast params + last -> row_param_en = 4'b1011 each cycle after acceptance; RUN after last.
REQ-027 Addressed param to row 2 with mask 4'b1011 -> row_param_en = 0, cfg_err = 1; data not forwarded.
REQ-028 RUN, row_act_req = 4'b0011 with mask 4'b1011 -> act_rdy = 0; set bit 3 -> act_rdy = 1, word 0xA5 on row_act_data next cycle.
REQ-029 DRAIN, rows 0,1,3 all valid, out_rdy = 1, DRAIN_WORDS = 2 -> out_row 0,1,3,0,1,3; done pulses on 6th handshake.
REQ-030 out_rdy held 0 for 5 cycles mid-DRAIN -> out_data stable, no row_pbuf_rdy, no word lost.
REQ-031 abort in RUN and rst_n low in DRAIN -> IDLE next cycle, all outputs 0, no done.
